rs_alu_scheduler: RTL and testbench
===================================

RS_ALU_SCHEDULER -- requirements
Module: rs_alu_scheduler

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, meaning number of reservation-station entries (power of two, 2..16).
REQ-002 SHALL have port clk_in  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports rdy_in  input  1  global stall (low = hold all state); clr_in  input  1  misprediction flush.
REQ-005 SHALL have issue ports: issue_valid 1; issue_op OPENUM_TYPE; issue_vj/issue_vk DATA_TYPE; issue_qj_valid/issue_qk_valid 1 (operand pending); issue_qj/issue_qk ROB_INDEX_TYPE; issue_imm DATA_TYPE; issue_pc ADDR_TYPE; issue_rob_index ROB_INDEX_TYPE; all inputs.
REQ-006 SHALL have output rs_full  1  no free entry for next cycle's issue.
REQ-007 SHALL have CDB inputs cdb_valid 1, cdb_rob_index ROB_INDEX_TYPE, cdb_value DATA_TYPE (operand wakeup).
REQ-008 SHALL have registered outputs rs_to_alu_ready 1, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_pc, rs_to_alu_rob_index (widths per type) driving the ALU.

Function
REQ-009 Each entry SHALL hold busy, op, vj, vk, qj_valid, qj, qk_valid, qk, imm, pc, rob_index.
REQ-010 Entry state per cycle: FREE -> WAIT (issue, some operand pending) or READY (issue, none pending); WAIT -> READY when last pending tag woken; READY -> FREE on dispatch.
REQ-011 On issue_valid with rdy_in high, lowest-index FREE entry SHALL be written; issue while rs_full high is a protocol error, ignored.
REQ-012 On cdb_valid, every busy entry with qj_valid and qj==cdb_rob_index SHALL capture vj<=cdb_value, clear qj_valid; same for k.
REQ-013 Same-cycle issue and CDB match SHALL capture cdb_value into the new entry (bypass), entry enters READY directly.
REQ-014 At most one READY entry SHALL be dispatched per cycle; selection per REQ-020; an entry woken this cycle is dispatchable next cycle at earliest.
REQ-015 Dispatch latency: selected entry -> rs_to_alu_* registered, valid the following cycle for exactly one cycle; rs_to_alu_ready low when nothing dispatched.
REQ-016 rs_full SHALL be high when free entries <=1 and issue_valid is high, or free entries ==0 (registered, conservative one-slot lookahead).
REQ-017 Simultaneous issue and dispatch in a full-minus-one RS SHALL both succeed; freed slot reusable next cycle, not same cycle.
REQ-018 rdy_in low SHALL freeze all entries and outputs; CDB and issue inputs ignored that cycle.
REQ-019 clr_in high (rdy_in irrelevant) SHALL free all entries and drop rs_to_alu_ready next edge; issue in that cycle discarded.

Configuration
REQ-020 Macro RS_AGE_SELECT_EN: defined -> oldest READY entry selected via RS_SIZE x RS_SIZE age matrix updated on issue; undefined -> lowest-index READY entry selected, no age state.

Reset
REQ-021 rst_n_in low SHALL asynchronously clear all busy bits, age state, rs_full, rs_to_alu_ready and all rs_to_alu_* data to 0.
REQ-022 Reset release SHALL leave the block accepting issue on the first subsequent edge.

Structure
REQ-023 OPENUM_TYPE, DATA_TYPE, ADDR_TYPE, ROB_INDEX_TYPE, RS_SIZE default and opcode enumeration SHALL live in the shared defines file.
REQ-024 Ready-entry selection SHALL be a separate sub-module rs_select (READY vector [+ age matrix] in, one-hot grant + valid out).

Verification
REQ-025 Issue ADDI op, vj=5, imm=7, no pending -> rs_to_alu_ready one cycle two edges later with rs1=5, imm=7, rob_index as issued.
REQ-026 Issue ADD with qj=3 pending, vk=2; cdb_valid rob 3 value 10 two cycles later -> dispatch next cycle with rs1=10, rs2=2.
REQ-027 Issue with qk=4 pending in same cycle as cdb rob 4 value 0xFFFF_FFFF -> dispatched with rs2=0xFFFF_FFFF, no further wakeup needed.
REQ-028 Fill 8 entries all pending -> rs_full high; one wakeup plus dispatch -> rs_full low, 9th issue accepted next cycle.
REQ-029 With RS_AGE_SELECT_EN, entry 5 issued before entry 1, both woken same cycle -> entry 5 dispatched first; without macro -> entry 1 first.
REQ-030 clr_in mid-operation with 4 busy entries, and rst_n_in pulsed low mid-cycle -> all entries free, rs_to_alu_ready 0, rs_full 0 (reset immediately, not at edge).

Source files
------------

// File: rtl/rs_alu_scheduler_pkg.sv
// Shared types for the ALU reservation station: opcodes, data/address/ROB tag types, entry layout.
// RS_AGE_SELECT_EN (optional macro) switches dispatch from lowest-index to oldest-ready selection.
package rs_alu_scheduler_pkg;

    localparam int RS_SIZE_DEF = 8;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int ROB_W       = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ROB_W-1:0]  rob_index_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_ADDI = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_SLT  = 4'd10,
        OP_SLTU = 4'd11,
        OP_BEQ  = 4'd12,
        OP_BNE  = 4'd13,
        OP_JAL  = 4'd14,
        OP_LUI  = 4'd15
    } openum_t;

    typedef struct packed {
        logic       busy;
        openum_t    op;
        data_t      vj;
        data_t      vk;
        logic       qj_valid;
        rob_index_t qj;
        logic       qk_valid;
        rob_index_t qk;
        data_t      imm;
        addr_t      pc;
        rob_index_t rob_index;
    } rs_entry_t;

endpackage

// File: rtl/rs_alu_scheduler_select.sv
// Ready-entry picker: one-hot grant out of the READY vector.
// With RS_AGE_SELECT_EN the oldest entry wins (age[i][j] = i older than j), else lowest index.
module rs_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]        ready,
`ifdef RS_AGE_SELECT_EN
    input  logic [N-1:0][N-1:0] age,
`endif
    output logic [N-1:0]        grant,
    output logic                valid
);

`ifdef RS_AGE_SELECT_EN
    logic older;

    always_comb begin
        grant = '0;
        older = 1'b0;
        for (int i = 0; i < N; i++) begin
            older = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (j != i && ready[j] && !age[i][j])
                    older = 1'b0;
            end
            grant[i] = ready[i] && older;
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (ready[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`endif

    assign valid = |ready;

endmodule

// File: rtl/rs_alu_scheduler.sv
// ALU reservation station: issue, CDB wakeup with issue bypass, single dispatch per cycle.
// Define RS_AGE_SELECT_EN to dispatch the oldest ready entry instead of the lowest index.
module rs_alu_scheduler
    import rs_alu_scheduler_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rdy_in,
    input  logic       clr_in,
    input  logic       issue_valid,
    input  openum_t    issue_op,
    input  data_t      issue_vj,
    input  data_t      issue_vk,
    input  logic       issue_qj_valid,
    input  logic       issue_qk_valid,
    input  rob_index_t issue_qj,
    input  rob_index_t issue_qk,
    input  data_t      issue_imm,
    input  addr_t      issue_pc,
    input  rob_index_t issue_rob_index,
    output logic       rs_full,
    input  logic       cdb_valid,
    input  rob_index_t cdb_rob_index,
    input  data_t      cdb_value,
    output logic       rs_to_alu_ready,
    output openum_t    rs_to_alu_op,
    output data_t      rs_to_alu_rs1,
    output data_t      rs_to_alu_rs2,
    output data_t      rs_to_alu_imm,
    output addr_t      rs_to_alu_pc,
    output rob_index_t rs_to_alu_rob_index
);

    localparam int CNT_W = $clog2(RS_SIZE + 1);

    rs_entry_t          ent [RS_SIZE];
    rs_entry_t          new_ent;
    rs_entry_t          sel_ent;
    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] alloc;
    logic [RS_SIZE-1:0] grant;
    logic               grant_valid;
    logic               issue_fire;
    logic               byp_j;
    logic               byp_k;
    logic [CNT_W-1:0]   free_cnt;

    always_comb begin
        busy      = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy[i]      = ent[i].busy;
            ready_vec[i] = ent[i].busy && !ent[i].qj_valid && !ent[i].qk_valid;
        end
    end

    // Descending scan so the lowest free index is the one left in alloc.
    always_comb begin
        alloc    = '0;
        free_cnt = '0;
        for (int i = RS_SIZE-1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc    = '0;
                alloc[i] = 1'b1;
                free_cnt = free_cnt + CNT_W'(1);
            end
        end
    end

    assign issue_fire = issue_valid && rdy_in && !clr_in && !rs_full;

    // A tag broadcast in the issue cycle is captured directly into the new entry.
    always_comb begin
        byp_j = cdb_valid && issue_qj_valid && (issue_qj == cdb_rob_index);
        byp_k = cdb_valid && issue_qk_valid && (issue_qk == cdb_rob_index);
        new_ent           = '0;
        new_ent.busy      = 1'b1;
        new_ent.op        = issue_op;
        new_ent.vj        = byp_j ? cdb_value : issue_vj;
        new_ent.vk        = byp_k ? cdb_value : issue_vk;
        new_ent.qj_valid  = issue_qj_valid && !byp_j;
        new_ent.qj        = issue_qj;
        new_ent.qk_valid  = issue_qk_valid && !byp_k;
        new_ent.qk        = issue_qk;
        new_ent.imm       = issue_imm;
        new_ent.pc        = issue_pc;
        new_ent.rob_index = issue_rob_index;
    end

`ifdef RS_AGE_SELECT_EN
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age;

    // New entry becomes younger than everything: clear its row, set its column.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            age <= '0;
        end else if (issue_fire) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc[i])
                    age[i] <= '0;
                else
                    age[i] <= age[i] | alloc;
            end
        end
    end

    rs_select #(.N(RS_SIZE)) u_select (
        .ready (ready_vec),
        .age   (age),
        .grant (grant),
        .valid (grant_valid)
    );
`else
    rs_select #(.N(RS_SIZE)) u_select (
        .ready (ready_vec),
        .grant (grant),
        .valid (grant_valid)
    );
`endif

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant[i])
                sel_ent = ent[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent[i] <= '0;
            rs_full             <= 1'b0;
            rs_to_alu_ready     <= 1'b0;
            rs_to_alu_op        <= OP_NOP;
            rs_to_alu_rs1       <= '0;
            rs_to_alu_rs2       <= '0;
            rs_to_alu_imm       <= '0;
            rs_to_alu_pc        <= '0;
            rs_to_alu_rob_index <= '0;
        end else if (clr_in) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent[i].busy <= 1'b0;
            rs_full         <= 1'b0;
            rs_to_alu_ready <= 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (grant_valid && grant[i]) begin
                    ent[i].busy <= 1'b0;
                end else if (issue_fire && alloc[i]) begin
                    ent[i] <= new_ent;
                end else if (ent[i].busy && cdb_valid) begin
                    if (ent[i].qj_valid && ent[i].qj == cdb_rob_index) begin
                        ent[i].vj       <= cdb_value;
                        ent[i].qj_valid <= 1'b0;
                    end
                    if (ent[i].qk_valid && ent[i].qk == cdb_rob_index) begin
                        ent[i].vk       <= cdb_value;
                        ent[i].qk_valid <= 1'b0;
                    end
                end
            end
            rs_to_alu_ready <= grant_valid;
            if (grant_valid) begin
                rs_to_alu_op        <= sel_ent.op;
                rs_to_alu_rs1       <= sel_ent.vj;
                rs_to_alu_rs2       <= sel_ent.vk;
                rs_to_alu_imm       <= sel_ent.imm;
                rs_to_alu_pc        <= sel_ent.pc;
                rs_to_alu_rob_index <= sel_ent.rob_index;
            end
            // Conservative: a slot freed by this cycle's dispatch is not counted.
            rs_full <= (free_cnt == '0) ||
                       (free_cnt <= CNT_W'(1) && issue_fire);
        end
    end

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Directed self-checking bench for rs_alu_scheduler (default RS_SIZE = 8).
module tb_rs_alu_scheduler;
    import rs_alu_scheduler_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       rdy_in;
    logic       clr_in;
    logic       issue_valid;
    openum_t    issue_op;
    data_t      issue_vj;
    data_t      issue_vk;
    logic       issue_qj_valid;
    logic       issue_qk_valid;
    rob_index_t issue_qj;
    rob_index_t issue_qk;
    data_t      issue_imm;
    addr_t      issue_pc;
    rob_index_t issue_rob_index;
    logic       rs_full;
    logic       cdb_valid;
    rob_index_t cdb_rob_index;
    data_t      cdb_value;
    logic       rs_to_alu_ready;
    openum_t    rs_to_alu_op;
    data_t      rs_to_alu_rs1;
    data_t      rs_to_alu_rs2;
    data_t      rs_to_alu_imm;
    addr_t      rs_to_alu_pc;
    rob_index_t rs_to_alu_rob_index;

    int checks = 0;
    int errors = 0;

    rs_alu_scheduler dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .rdy_in              (rdy_in),
        .clr_in              (clr_in),
        .issue_valid         (issue_valid),
        .issue_op            (issue_op),
        .issue_vj            (issue_vj),
        .issue_vk            (issue_vk),
        .issue_qj_valid      (issue_qj_valid),
        .issue_qk_valid      (issue_qk_valid),
        .issue_qj            (issue_qj),
        .issue_qk            (issue_qk),
        .issue_imm           (issue_imm),
        .issue_pc            (issue_pc),
        .issue_rob_index     (issue_rob_index),
        .rs_full             (rs_full),
        .cdb_valid           (cdb_valid),
        .cdb_rob_index       (cdb_rob_index),
        .cdb_value           (cdb_value),
        .rs_to_alu_ready     (rs_to_alu_ready),
        .rs_to_alu_op        (rs_to_alu_op),
        .rs_to_alu_rs1       (rs_to_alu_rs1),
        .rs_to_alu_rs2       (rs_to_alu_rs2),
        .rs_to_alu_imm       (rs_to_alu_imm),
        .rs_to_alu_pc        (rs_to_alu_pc),
        .rs_to_alu_rob_index (rs_to_alu_rob_index)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_op       = OP_NOP;
        issue_vj       = '0;
        issue_vk       = '0;
        issue_qj_valid = 1'b0;
        issue_qk_valid = 1'b0;
        issue_qj       = '0;
        issue_qk       = '0;
        issue_imm      = '0;
        issue_pc       = '0;
        issue_rob_index = '0;
        cdb_valid      = 1'b0;
        cdb_rob_index  = '0;
        cdb_value      = '0;
    endtask

    task automatic issue(input openum_t op, input data_t vj, input data_t vk,
                         input logic qjv, input rob_index_t qj,
                         input logic qkv, input rob_index_t qk,
                         input data_t imm, input rob_index_t rob);
        issue_valid     = 1'b1;
        issue_op        = op;
        issue_vj        = vj;
        issue_vk        = vk;
        issue_qj_valid  = qjv;
        issue_qj        = qj;
        issue_qk_valid  = qkv;
        issue_qk        = qk;
        issue_imm       = imm;
        issue_pc        = 32'h1000 + 32'(rob) * 4;
        issue_rob_index = rob;
    endtask

    task automatic cdb(input rob_index_t rob, input data_t val);
        cdb_valid     = 1'b1;
        cdb_rob_index = rob;
        cdb_value     = val;
    endtask

    logic [3:0] qtags [6];
    logic [3:0] first_rob;
    logic [3:0] second_rob;

    initial begin
        idle();
        rdy_in   = 1'b1;
        clr_in   = 1'b0;
        rst_n_in = 1'b0;
        #12;
        check("reset_ready", 32'(rs_to_alu_ready), 32'd0);
        check("reset_full", 32'(rs_full), 32'd0);
        check("reset_rob", 32'(rs_to_alu_rob_index), 32'd0);
        rst_n_in = 1'b1;
        tick();

        // ADDI, no pending operands: output two edges after issue
        issue(OP_ADDI, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd7, 4'd2);
        tick();
        idle();
        check("addi_not_yet", 32'(rs_to_alu_ready), 32'd0);
        tick();
        check("addi_ready", 32'(rs_to_alu_ready), 32'd1);
        check("addi_rs1", rs_to_alu_rs1, 32'd5);
        check("addi_imm", rs_to_alu_imm, 32'd7);
        check("addi_rob", 32'(rs_to_alu_rob_index), 32'd2);
        check("addi_op", 32'(rs_to_alu_op), 32'(OP_ADDI));
        check("addi_pc", rs_to_alu_pc, 32'h1008);
        rdy_in = 1'b0;
        tick();
        check("stall_hold_ready", 32'(rs_to_alu_ready), 32'd1);
        check("stall_hold_rob", 32'(rs_to_alu_rob_index), 32'd2);
        rdy_in = 1'b1;
        tick();
        check("addi_one_cycle", 32'(rs_to_alu_ready), 32'd0);

        // Issue while stalled is ignored
        rdy_in = 1'b0;
        issue(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd3);
        tick();
        idle();
        rdy_in = 1'b1;
        tick();
        tick();
        check("stall_issue_drop", 32'(rs_to_alu_ready), 32'd0);

        // ADD waiting on tag 3, woken two cycles later
        issue(OP_ADD, 32'd0, 32'd2, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 4'd5);
        tick();
        idle();
        tick();
        check("wait_no_dispatch", 32'(rs_to_alu_ready), 32'd0);
        cdb(4'd3, 32'd10);
        tick();
        idle();
        check("woken_not_yet", 32'(rs_to_alu_ready), 32'd0);
        tick();
        check("wake_ready", 32'(rs_to_alu_ready), 32'd1);
        check("wake_rs1", rs_to_alu_rs1, 32'd10);
        check("wake_rs2", rs_to_alu_rs2, 32'd2);
        check("wake_rob", 32'(rs_to_alu_rob_index), 32'd5);
        tick();

        // Same-cycle CDB bypass into the issuing entry
        issue(OP_SUB, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 32'd0, 4'd6);
        cdb(4'd4, 32'hFFFF_FFFF);
        tick();
        idle();
        tick();
        check("bypass_ready", 32'(rs_to_alu_ready), 32'd1);
        check("bypass_rs2", rs_to_alu_rs2, 32'hFFFF_FFFF);
        check("bypass_rs1", rs_to_alu_rs1, 32'd1);
        check("bypass_rob", 32'(rs_to_alu_rob_index), 32'd6);
        tick();

        // Fill all 8 entries, each pending on tag 8+i
        for (int i = 0; i < 8; i++) begin
            check("fill_not_full", 32'(rs_full), 32'd0);
            issue(OP_ADD, 32'd0, 32'd0, 1'b1, 4'(8 + i), 1'b0, 4'd0,
                  32'd0, 4'(i));
            tick();
        end
        idle();
        check("fill_full", 32'(rs_full), 32'd1);
        issue(OP_ADDI, 32'd3, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd15);
        tick();
        idle();
        check("full_still", 32'(rs_full), 32'd1);
        tick();
        check("full_issue_drop", 32'(rs_to_alu_ready), 32'd0);
        cdb(4'd8, 32'h55);
        tick();
        idle();
        check("full_after_wake", 32'(rs_full), 32'd1);
        tick();
        check("full_disp_ready", 32'(rs_to_alu_ready), 32'd1);
        check("full_disp_rob", 32'(rs_to_alu_rob_index), 32'd0);
        check("full_disp_rs1", rs_to_alu_rs1, 32'h55);
        check("full_same_cycle", 32'(rs_full), 32'd1);
        tick();
        check("full_released", 32'(rs_full), 32'd0);
        issue(OP_ADDI, 32'h99, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd12);
        tick();
        idle();
        check("ninth_full_again", 32'(rs_full), 32'd1);
        tick();
        check("ninth_ready", 32'(rs_to_alu_ready), 32'd1);
        check("ninth_rob", 32'(rs_to_alu_rob_index), 32'd12);
        check("ninth_rs1", rs_to_alu_rs1, 32'h99);
        tick();
        check("minus_one_free", 32'(rs_full), 32'd0);

        // Full-minus-one: issue and dispatch on the same edge
        cdb(4'd9, 32'h11);
        tick();
        idle();
        check("mo_not_full", 32'(rs_full), 32'd0);
        issue(OP_OR, 32'h77, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd13);
        tick();
        idle();
        check("mo_disp_ready", 32'(rs_to_alu_ready), 32'd1);
        check("mo_disp_rob", 32'(rs_to_alu_rob_index), 32'd1);
        check("mo_disp_rs1", rs_to_alu_rs1, 32'h11);
        tick();
        check("mo_issue_ready", 32'(rs_to_alu_ready), 32'd1);
        check("mo_issue_rob", 32'(rs_to_alu_rob_index), 32'd13);
        check("mo_issue_rs1", rs_to_alu_rs1, 32'h77);

        // Flush with six entries busy; the concurrent issue is discarded
        clr_in = 1'b1;
        issue(OP_ADDI, 32'd1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd14);
        tick();
        clr_in = 1'b0;
        idle();
        check("clr_ready", 32'(rs_to_alu_ready), 32'd0);
        check("clr_full", 32'(rs_full), 32'd0);
        tick();
        check("clr_issue_drop", 32'(rs_to_alu_ready), 32'd0);
        cdb(4'd10, 32'd1);
        tick();
        idle();
        tick();
        check("clr_entries_free", 32'(rs_to_alu_ready), 32'd0);

        // Selection order: entry 5 older than a re-issued entry 1
        qtags = '{4'd8, 4'd7, 4'd8, 4'd8, 4'd8, 4'd9};
        for (int i = 0; i < 6; i++) begin
            issue(OP_AND, 32'd0, 32'd0, 1'b1, qtags[i], 1'b0, 4'd0,
                  32'd0, 4'(i));
            tick();
        end
        idle();
        cdb(4'd7, 32'h21);
        tick();
        idle();
        tick();
        check("age_e1_ready", 32'(rs_to_alu_ready), 32'd1);
        check("age_e1_rob", 32'(rs_to_alu_rob_index), 32'd1);
        issue(OP_XOR, 32'd0, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, 32'd0, 4'd10);
        tick();
        idle();
        cdb(4'd9, 32'h42);
        tick();
        idle();
        check("age_wait", 32'(rs_to_alu_ready), 32'd0);
`ifdef RS_AGE_SELECT_EN
        first_rob  = 4'd5;
        second_rob = 4'd10;
`else
        first_rob  = 4'd10;
        second_rob = 4'd5;
`endif
        tick();
        check("sel_first_ready", 32'(rs_to_alu_ready), 32'd1);
        check("sel_first_rob", 32'(rs_to_alu_rob_index), 32'(first_rob));
        check("sel_first_rs1", rs_to_alu_rs1, 32'h42);
        tick();
        check("sel_second_ready", 32'(rs_to_alu_ready), 32'd1);
        check("sel_second_rob", 32'(rs_to_alu_rob_index), 32'(second_rob));

        // Asynchronous reset mid-cycle with four entries still busy
        #2;
        rst_n_in = 1'b0;
        #1;
        check("arst_ready", 32'(rs_to_alu_ready), 32'd0);
        check("arst_full", 32'(rs_full), 32'd0);
        check("arst_rob", 32'(rs_to_alu_rob_index), 32'd0);
        check("arst_rs1", rs_to_alu_rs1, 32'd0);
        #1;
        rst_n_in = 1'b1;
        tick();
        cdb(4'd8, 32'd3);
        tick();
        idle();
        tick();
        check("arst_entries_free", 32'(rs_to_alu_ready), 32'd0);
        issue(OP_LUI, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'hABC, 4'd7);
        tick();
        idle();
        tick();
        check("post_rst_ready", 32'(rs_to_alu_ready), 32'd1);
        check("post_rst_rob", 32'(rs_to_alu_rob_index), 32'd7);
        check("post_rst_imm", rs_to_alu_imm, 32'hABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
